// File: rtl/response_transmitter_pkg.sv
// response_transmitter_pkg: shared FSM state type and constants for the UART response transmitter
package response_transmitter_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
   localparam int DATA_BITS = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 868;
endpackage

// File: rtl/response_transmitter_if.sv
// response_transmitter_if: byte-queue write side and UART line/status of the transmitter
// Word_To_Send/Send_Word: byte and write strobe; Send_Ready: queue not full
// Tx: serial line; Tx_Busy: frame in progress or bytes queued; Overflow: sticky dropped write
interface response_transmitter_if;
   import response_transmitter_pkg::*;
   logic [DATA_BITS-1:0] Word_To_Send;
   logic Send_Word, Send_Ready, Tx, Tx_Busy, Overflow;
   modport master (output Word_To_Send, Send_Word, input Send_Ready, Tx, Tx_Busy, Overflow);
   modport slave (input Word_To_Send, Send_Word, output Send_Ready, Tx, Tx_Busy, Overflow);
endinterface

// File: rtl/response_transmitter_fifo.sv
// response_fifo: byte queue with synchronous write/pop and registered occupancy
// wr_en/wr_data: write (ignored when full); rd_en: pop (ignored when empty)
// rd_data: head entry; full/empty/count: occupancy status
module response_fifo import response_transmitter_pkg::*; #(
   parameter int DEPTH = 4,
   parameter int WIDTH = DATA_BITS
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic push, pop;
   assign full = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
   assign push = wr_en && !full;
   assign pop = rd_en && !empty;
   assign rd_data = mem[rd_ptr];
   // DEPTH is a power of two, so pointers wrap by natural overflow
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
         rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/response_transmitter.sv
// response_transmitter: queued UART 8N1 transmitter for response bytes
// clk/reset: system clock, async active-high reset; bus: queue write side, Tx line and status
module response_transmitter import response_transmitter_pkg::*; #(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   response_transmitter_if.slave  bus
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);
   tx_state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [BW-1:0] bit_idx, bit_n;
   logic [DATA_BITS-1:0] shreg, sh_n, head;
   logic tx, tx_n, pop, full, empty, last, overflow;
   logic [$clog2(FIFO_DEPTH):0] occ;
   response_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_fifo (
      .clk(clk), .reset(reset), .wr_en(bus.Send_Word), .wr_data(bus.Word_To_Send),
      .rd_en(pop), .rd_data(head), .full(full), .empty(empty), .count(occ)
   );
   assign bus.Send_Ready = !full;
   assign bus.Tx = tx;
   assign bus.Tx_Busy = state != IDLE || occ != '0;
   assign bus.Overflow = overflow;
   assign last = cnt == CW'(CLKS_PER_BIT - 1);
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         bit_idx <= '0;
         shreg <= '0;
         tx <= 1'b1;
         overflow <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         bit_idx <= bit_n;
         shreg <= sh_n;
         tx <= tx_n;
         overflow <= overflow | (bus.Send_Word & full);
      end
   // Tx is registered from the current state, so the line lags the state by one clock
   // and every level is still held for exactly CLKS_PER_BIT clocks
   always_comb begin
      state_n = state;
      bit_n = bit_idx;
      sh_n = shreg;
      pop = 1'b0;
      cnt_n = (state == IDLE || last) ? '0 : cnt + CW'(1);
      tx_n = state == START ? 1'b0 : state == DATA ? shreg[0] : 1'b1;
      case (state)
         IDLE: if (!empty) begin
            pop = 1'b1;
            sh_n = head;
            bit_n = '0;
            state_n = START;
         end
         START: state_n = last ? DATA : START;
         DATA: if (last) begin
            sh_n = shreg >> 1;
            bit_n = bit_idx + BW'(1);
            state_n = bit_idx == BW'(DATA_BITS - 1) ? STOP : DATA;
         end
         default: state_n = last ? IDLE : STOP;
      endcase
   end
endmodule

// File: tb/tb_response_transmitter.sv
// tb_response_transmitter: scoreboard bench for the UART response transmitter
module tb_response_transmitter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int cyc = 0, checks = 0, fails = 0, last_wr = 0, n0 = 0;
   logic [7:0] sb [$];
   int starts [$];
   logic [9:0] lvl;
   logic bad, aborted;
   logic [7:0] exp_b;

   response_transmitter_if bus();
   response_transmitter #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
      end
   endtask

   task automatic send(input logic [7:0] b, input logic rdy);
      bus.Word_To_Send = b;
      bus.Send_Word = 1'b1;
      chk("send_ready", bus.Send_Ready, rdy);
      if (rdy) sb.push_back(b);
      @(negedge clk);
      last_wr = cyc;
   endtask

   task automatic idle(input int n);
      bus.Send_Word = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 2000 && sb.size() > 0; i++) @(negedge clk);
      chk("drain_empty", sb.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   // monitor: frames are sampled at negedges; a frame is 40 samples, 4 per level
   initial forever begin
      @(negedge clk);
      if (!reset && bus.Tx === 1'b0) begin
         starts.push_back(cyc);
         bad = 1'b0;
         aborted = 1'b0;
         lvl = '0;
         for (int s = 0; s < 40 && !aborted; s++) begin
            if (s > 0) @(negedge clk);
            if (reset) aborted = 1'b1;
            else if (s % 4 == 0) lvl[s/4] = bus.Tx;
            else if (bus.Tx !== lvl[s/4]) bad = 1'b1;
         end
         if (!aborted) begin
            if (sb.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_frame: got line %b expected no frame", lvl);
            end else begin
               exp_b = sb.pop_front();
               chk("frame", lvl, {1'b1, exp_b, 1'b0});
               chk("bit_hold", bad, 0);
            end
         end
      end
   end

   initial begin
      bus.Send_Word = 1'b0;
      bus.Word_To_Send = '0;
      repeat (3) @(negedge clk);
      chk("in_reset", {bus.Tx, bus.Tx_Busy, bus.Send_Ready, bus.Overflow}, 4'b1010);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_outputs", {bus.Tx, bus.Tx_Busy, bus.Send_Ready, bus.Overflow}, 4'b1010);
      end
      // single byte: latency and busy drop after stop
      n0 = starts.size();
      send(8'h30, 1'b1);
      idle(40);
      chk("busy_in_stop", bus.Tx_Busy, 1);
      idle(1);
      chk("busy_after_stop", bus.Tx_Busy, 0);
      drain();
      chk("latency", starts.size() > n0 ? starts[n0] : -1, last_wr + 2);
      // back-to-back frames
      n0 = starts.size();
      send(8'h55, 1'b1);
      send(8'hAA, 1'b1);
      idle(1);
      drain();
      chk("spacing_55_aa", starts.size() > n0 + 1 ? starts[n0+1] - starts[n0] : -1, 41);
      // overflow: sixth write dropped
      for (int i = 1; i <= 6; i++) send(8'(i), i < 6);
      idle(1);
      chk("overflow_set", bus.Overflow, 1);
      drain();
      chk("overflow_held", bus.Overflow, 1);
      reset = 1'b1;
      @(negedge clk);
      chk("overflow_cleared", bus.Overflow, 0);
      reset = 1'b0;
      idle(2);
      // write coinciding with the pop of the last queued byte
      n0 = starts.size();
      send(8'hC3, 1'b1);
      send(8'h3C, 1'b1);
      idle(40);
      send(8'h99, 1'b1);
      chk("occupancy", 32'(dut.u_fifo.count), 1);
      idle(1);
      drain();
      chk("spacing_3c_99", starts.size() > n0 + 2 ? starts[n0+2] - starts[n0+1] : -1, 41);
      // reset during data bit 3 with two bytes queued
      send(8'h0F, 1'b1);
      send(8'h11, 1'b1);
      send(8'h22, 1'b1);
      idle(16);
      reset = 1'b1;
      #1;
      chk("abort_outputs", {bus.Tx, bus.Tx_Busy, bus.Send_Ready, bus.Overflow}, 4'b1010);
      sb.delete();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      n0 = starts.size();
      repeat (60) @(negedge clk);
      chk("no_frame_after_abort", starts.size(), n0);
      chk("quiet_after_abort", {bus.Tx, bus.Tx_Busy}, 2'b10);
      // first write right after reset release, then a fresh reset-free release case
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n0 = starts.size();
      send(8'h5A, 1'b1);
      idle(1);
      drain();
      chk("latency_after_reset", starts.size() > n0 ? starts[n0] : -1, last_wr + 2);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
